// File: rtl/alu.sv
// Registered 16-bit ALU: arithmetic, logic, single-bit shifts/rotates with
// signed-overflow and negative flags, one-cycle latency.
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [3:0]  opcode,
    output logic [15:0] Result,
    output logic        V,
    output logic        N
);

    typedef enum logic [3:0] {
        OP_NEG = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_MUL = 4'b0011,
        OP_AND = 4'b0100,
        OP_OR  = 4'b0101,
        OP_XOR = 4'b0110,
        OP_LSL = 4'b0111,
        OP_LSR = 4'b1000,
        OP_ASL = 4'b1001,
        OP_ASR = 4'b1010,
        OP_ROL = 4'b1011,
        OP_ROR = 4'b1100
    } op_t;

    logic [15:0] neg_res;
    logic [15:0] add_res;
    logic [15:0] sub_res;
    logic [31:0] product;
    logic        neg_v;
    logic        add_v;
    logic        sub_v;
    logic        mul_v;
    logic        asl_v;

    logic [15:0] next_result;
    logic        next_v;
    logic        next_n;
    logic        defined_op;

    // Arithmetic datapaths; carry out of bit 15 is simply dropped.
    always_comb begin
        neg_res = (~A) + 16'd1;
        add_res = A + B;
        sub_res = A - B;
        product = $signed(A) * $signed(B);

        neg_v = (A == 16'h8000);
        add_v = (A[15] == B[15]) && (add_res[15] != A[15]);
        sub_v = (A[15] != B[15]) && (sub_res[15] != A[15]);
        mul_v = !((product[31:15] == 17'h00000) || (product[31:15] == 17'h1FFFF));
        asl_v = (A[15] != A[14]);
    end

    always_comb begin
        next_result = 16'h0000;
        next_v      = 1'b0;
        defined_op  = 1'b1;
        case (op_t'(opcode))
            OP_NEG: begin
                next_result = neg_res;
                next_v      = neg_v;
            end
            OP_ADD: begin
                next_result = add_res;
                next_v      = add_v;
            end
            OP_SUB: begin
                next_result = sub_res;
                next_v      = sub_v;
            end
            OP_MUL: begin
                next_result = product[15:0];
                next_v      = mul_v;
            end
            OP_AND: next_result = A & B;
            OP_OR:  next_result = A | B;
            OP_XOR: next_result = A ^ B;
            OP_LSL: next_result = {A[14:0], 1'b0};
            OP_LSR: next_result = {1'b0, A[15:1]};
            OP_ASL: begin
                next_result = {A[14:0], 1'b0};
                next_v      = asl_v;
            end
            OP_ASR: next_result = {A[15], A[15:1]};
            OP_ROL: next_result = {A[14:0], A[15]};
            OP_ROR: next_result = {A[0], A[15:1]};
            default: defined_op = 1'b0;
        endcase
        next_n = defined_op & next_result[15];
    end

    // Reset wins over whatever operation is presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            Result <= 16'h0000;
            V      <= 1'b0;
            N      <= 1'b0;
        end else begin
            Result <= next_result;
            V      <= next_v;
            N      <= next_n;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: integer-arithmetic reference model checked
// every cycle, plus directed literal vectors.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  opcode;
    logic [15:0] Result;
    logic        V;
    logic        N;

    int compared;
    int mismatched;

    alu dut (
        .clk(clk),
        .rst(rst),
        .A(A),
        .B(B),
        .opcode(opcode),
        .Result(Result),
        .V(V),
        .N(N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model in plain signed/unsigned integer arithmetic.
    // Returns {result, v, n}.
    function automatic logic [17:0] model(input logic r, input logic [3:0] op,
                                          input logic [15:0] a, input logic [15:0] b);
        int sa;
        int sb;
        int ua;
        int t;
        logic [15:0] res;
        logic v;
        logic n;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        t = 0;
        res = 16'h0000;
        v = 1'b0;
        if (r) return 18'h0;
        case (op)
            4'd0: begin t = -sa; res = t[15:0]; v = (t > 32767); end
            4'd1: begin t = sa + sb; res = t[15:0]; v = (t > 32767) || (t < -32768); end
            4'd2: begin t = sa - sb; res = t[15:0]; v = (t > 32767) || (t < -32768); end
            4'd3: begin t = sa * sb; res = t[15:0]; v = (t > 32767) || (t < -32768); end
            4'd4: res = a & b;
            4'd5: res = a | b;
            4'd6: res = a ^ b;
            4'd7: begin t = (ua * 2) % 65536; res = t[15:0]; end
            4'd8: begin t = ua / 2; res = t[15:0]; end
            4'd9: begin t = sa * 2; res = t[15:0]; v = (t > 32767) || (t < -32768); end
            4'd10: begin t = sa >>> 1; res = t[15:0]; end
            4'd11: begin t = ((ua * 2) % 65536) + (ua / 32768); res = t[15:0]; end
            4'd12: begin t = (ua / 2) + (ua % 2) * 32768; res = t[15:0]; end
            default: return 18'h0;
        endcase
        n = res[15];
        return {res, v, n};
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] exp_r,
                               input logic exp_v, input logic exp_n);
        compared++;
        if (Result !== exp_r || V !== exp_v || N !== exp_n) begin
            mismatched++;
            $display("[TB] FAIL %s: got Result=%h V=%b N=%b, want Result=%h V=%b N=%b",
                     name, Result, V, N, exp_r, exp_v, exp_n);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] op,
                                 input logic [15:0] a, input logic [15:0] b);
        rst = r;
        opcode = op;
        A = a;
        B = b;
    endtask

    // Applies a vector, waits for its capture edge, checks the DUT against a
    // hand-computed literal and confirms the model agrees with that literal.
    task automatic directed(input string name, input logic r, input logic [3:0] op,
                            input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] exp_r, input logic exp_v, input logic exp_n);
        logic [17:0] m;
        applyStimulus(r, op, a, b);
        @(posedge clk);
        #2;
        checkOutput(name, exp_r, exp_v, exp_n);
        m = model(r, op, a, b);
        compared++;
        if (m !== {exp_r, exp_v, exp_n}) begin
            mismatched++;
            $display("[TB] FAIL model_%s: model=%h want=%h", name, m, {exp_r, exp_v, exp_n});
        end
        #1;
    endtask

    // Every cycle: capture inputs at the edge, compare on the falling edge.
    logic [17:0] expected;
    always begin
        @(posedge clk);
        expected = model(rst, opcode, A, B);
        @(negedge clk);
        checkOutput("model", expected[17:2], expected[1], expected[0]);
    end

    initial begin
        compared = 0;
        mismatched = 0;
        applyStimulus(1'b1, 4'd1, 16'h7FFF, 16'h0001);
        @(posedge clk);
        #1;
        directed("reset", 1'b1, 4'd0, 16'h8000, 16'h0000, 16'h0000, 1'b0, 1'b0);

        directed("neg_ffff", 1'b0, 4'd0, 16'hFFFF, 16'h0000, 16'h0001, 1'b0, 1'b0);
        directed("neg_8000", 1'b0, 4'd0, 16'h8000, 16'h1234, 16'h8000, 1'b1, 1'b1);
        directed("add_small", 1'b0, 4'd1, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);
        directed("add_ovf", 1'b0, 4'd1, 16'h7FFF, 16'h001E, 16'h801D, 1'b1, 1'b1);
        directed("add_carry", 1'b0, 4'd1, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0);
        directed("sub_small", 1'b0, 4'd2, 16'd120, 16'd100, 16'h0014, 1'b0, 1'b0);
        directed("sub_ovf", 1'b0, 4'd2, 16'h8000, 16'h001E, 16'h7FE2, 1'b1, 1'b0);
        directed("mul_pos", 1'b0, 4'd3, 16'd123, 16'd123, 16'h3B19, 1'b0, 1'b0);
        directed("mul_neg", 1'b0, 4'd3, 16'd123, 16'hFF85, 16'hC4E7, 1'b0, 1'b1);
        directed("mul_ovf", 1'b0, 4'd3, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0);
        directed("mul_min", 1'b0, 4'd3, 16'hFF00, 16'h0080, 16'h8000, 1'b0, 1'b1);
        directed("and", 1'b0, 4'd4, 16'h7FED, 16'h1111, 16'h1101, 1'b0, 1'b0);
        directed("or", 1'b0, 4'd5, 16'h7FED, 16'h1111, 16'h7FFD, 1'b0, 1'b0);
        directed("xor", 1'b0, 4'd6, 16'h7FED, 16'h1111, 16'h6EFC, 1'b0, 1'b0);
        directed("lsl", 1'b0, 4'd7, 16'h7FED, 16'hFFFF, 16'hFFDA, 1'b0, 1'b1);
        directed("asl", 1'b0, 4'd9, 16'h7FED, 16'h0000, 16'hFFDA, 1'b1, 1'b1);
        directed("rol", 1'b0, 4'd11, 16'h7FED, 16'h0000, 16'hFFDA, 1'b0, 1'b1);
        directed("ror", 1'b0, 4'd12, 16'h7FED, 16'h0000, 16'hBFF6, 1'b0, 1'b1);
        directed("lsr", 1'b0, 4'd8, 16'hAFED, 16'h0000, 16'h57F6, 1'b0, 1'b0);
        directed("asr", 1'b0, 4'd10, 16'hAFED, 16'h0000, 16'hD7F6, 1'b0, 1'b1);
        directed("rol_msb", 1'b0, 4'd11, 16'h8001, 16'h0000, 16'h0003, 1'b0, 1'b0);
        directed("undef_f", 1'b0, 4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
        directed("undef_d", 1'b0, 4'd13, 16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b0);

        // Back-to-back stream interrupted by reset.
        directed("stream_add", 1'b0, 4'd1, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);
        directed("stream_rst", 1'b1, 4'd0, 16'h8000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        directed("stream_after", 1'b0, 4'd2, 16'd120, 16'd100, 16'h0014, 1'b0, 1'b0);

        // Random traffic with mid-cycle input churn, checked by the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)),
                          16'($urandom), 16'($urandom));
            @(posedge clk);
            #2;
            if (i % 3 == 0) begin
                A = 16'($urandom);
                B = 16'($urandom);
                opcode = 4'($urandom);
            end
            #1;
        end

        applyStimulus(1'b0, 4'd0, 16'h0000, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
